// File: rtl/mux_scan_serializer_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_serializer_pkg : shared widths, FSM encoding and scan-end helper
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mux_scan_serializer_pkg;

  localparam int SEL_W  = 3;
  localparam int WORD_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Highest select when scanning downward, zero when scanning upward.
  function automatic logic [SEL_W-1:0] scan_start(input bit msb_first);
    return msb_first ? SEL_W'(WORD_W - 1) : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux8_1_2_1.sv
// ---------------------------------------------------------------------------
// mux8_1_2_1 : 8:1 single-bit multiplexer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux8_1_2_1
  import mux_scan_serializer_pkg::*;
(
  output logic              out,
  input  logic [SEL_W-1:0]  sel,
  input  logic [WORD_W-1:0] in
);

  assign out = in[sel];

endmodule

`default_nettype wire

// File: rtl/mux_scan_serializer.sv
// ---------------------------------------------------------------------------
// mux_scan_serializer : valid/ready word loader scanning an 8:1 mux to serial
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_ready,
  input  logic              ser_ready,
  output logic              ser_valid,
  output logic              ser_out,
  output logic              ser_first,
  output logic              ser_last,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  localparam logic [SEL_W-1:0] C_START = scan_start(MSB_FIRST);
  localparam logic [SEL_W-1:0] C_END   = scan_start(!MSB_FIRST);

  state_e              r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_data,  w_data_nxt;
  logic [SEL_W-1:0]    r_sel,   w_sel_nxt;
  logic                w_accept;
  logic                w_xfer;
  logic                w_mux_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  assign ser_valid  = (r_state == SHIFT);
  assign busy       = ser_valid;
  assign ser_first  = ser_valid & (r_sel == C_START);
  assign ser_last   = ser_valid & (r_sel == C_END);
  assign sel        = r_sel;

  // A new word may enter while idle or alongside the final beat, so words
  // stream back-to-back without a bubble.
  assign load_ready = !rst & (!ser_valid | (ser_last & ser_ready));
  assign w_accept   = load_valid & load_ready;
  assign w_xfer     = ser_valid & ser_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_sel_nxt   = r_sel;
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_data_nxt  = load_data;
      w_sel_nxt   = C_START;
    end else if (w_xfer) begin
      if (ser_last) begin
        w_state_nxt = IDLE;
        w_sel_nxt   = '0;
      end else begin
        w_sel_nxt = MSB_FIRST ? (r_sel - 1'b1) : (r_sel + 1'b1);
      end
    end
  end

  mux8_1_2_1 u_mux (
    .out (w_mux_out),
    .sel (r_sel),
    .in  (r_data)
  );

  assign ser_out = w_mux_out & ser_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_serializer.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_serializer : directed checks on LSB-first and MSB-first instances
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux_scan_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       ser_ready = 1'b1;

  logic       lr0, sv0, so0, sf0, sl0, bz0;
  logic [2:0] sel0;
  logic       lr1, sv1, so1, sf1, sl1, bz1;
  logic [2:0] sel1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_scan_serializer #(.MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr0), .ser_ready(ser_ready), .ser_valid(sv0), .ser_out(so0),
    .ser_first(sf0), .ser_last(sl0), .sel(sel0), .busy(bz0)
  );

  mux_scan_serializer #(.MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr1), .ser_ready(ser_ready), .ser_valid(sv1), .ser_out(so1),
    .ser_first(sf1), .ser_last(sl1), .sel(sel1), .busy(bz1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs at the falling edge, then sample shortly after.
  task automatic drive(input logic r, input logic lv, input logic [7:0] ld, input logic sr);
    @(negedge clk);
    rst = r; load_valid = lv; load_data = ld; ser_ready = sr;
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_v0"}, {29'd0, sv0, bz0, so0}, 32'd0);
    chk({tag, "_v1"}, {29'd0, sv1, bz1, so1}, 32'd0);
    chk({tag, "_sel"}, {26'd0, sel0, sel1}, 32'd0);
    chk({tag, "_fl"}, {28'd0, sf0, sl0, sf1, sl1}, 32'd0);
  endtask

  // Beat k of word w: LSB-first instance shows w[k], MSB-first shows w[7-k].
  task automatic check_beat(input string tag, input int k, input logic [7:0] w, input logic lr_exp);
    logic [7:0] wv;
    wv = w;
    chk({tag, "_valid"}, {28'd0, sv0, bz0, sv1, bz1}, 32'hF);
    chk({tag, "_out0"}, {31'd0, so0}, {31'd0, wv[k]});
    chk({tag, "_out1"}, {31'd0, so1}, {31'd0, wv[7-k]});
    chk({tag, "_sel0"}, {29'd0, sel0}, k);
    chk({tag, "_sel1"}, {29'd0, sel1}, 7 - k);
    chk({tag, "_first"}, {30'd0, sf0, sf1}, (k == 0) ? 32'd3 : 32'd0);
    chk({tag, "_last"}, {30'd0, sl0, sl1}, (k == 7) ? 32'd3 : 32'd0);
    chk({tag, "_lready"}, {30'd0, lr0, lr1}, lr_exp ? 32'd3 : 32'd0);
  endtask

  initial begin
    // Reset state
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b1, 8'h55, 1'b1);
    chk("rst_lready", {30'd0, lr0, lr1}, 32'd0);
    check_idle("rst");
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rel_lready", {30'd0, lr0, lr1}, 32'd3);
    check_idle("rel");

    // Single word 0xAA, no stall: dut0 0,1,0,1..., dut1 1,0,1,0...
    drive(1'b0, 1'b1, 8'hAA, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check_beat("aa", k, 8'hAA, k == 7);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check_idle("aa_end");

    // Single word 0xF0: dut1 emits 1,1,1,1,0,0,0,0
    drive(1'b0, 1'b1, 8'hF0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check_beat("f0", k, 8'hF0, k == 7);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check_idle("f0_end");

    // 0xAA with a 3-cycle stall at beat 3
    drive(1'b0, 1'b1, 8'hAA, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        for (int s = 0; s < 3; s++) begin
          drive(1'b0, 1'b0, 8'h00, 1'b0);
          chk("stall_sel0", {29'd0, sel0}, 32'd3);
          chk("stall_out0", {30'd0, sv0, so0}, 32'd3);
          chk("stall_lready", {30'd0, lr0, lr1}, 32'd0);
        end
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check_beat("stall", k, 8'hAA, k == 7);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check_idle("stall_end");

    // Back-to-back 0xAA then 0xF0 with load_valid held
    drive(1'b0, 1'b1, 8'hAA, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 8'hF0, 1'b1);
      check_beat("b2b_a", k, 8'hAA, k == 7);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check_beat("b2b_b", k, 8'hF0, k == 7);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check_idle("b2b_end");

    // 0xFF offered during beats 0-6 of a 0x00 word loads only at the last beat
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 8'hFF, 1'b1);
      check_beat("ign_z", k, 8'h00, k == 7);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check_beat("ign_f", k, 8'hFF, k == 7);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check_idle("ign_end");

    // Reset at beat 4 together with a load request
    drive(1'b0, 1'b1, 8'hAA, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check_beat("mid", k, 8'hAA, 1'b0);
    end
    drive(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("mid_rst_lready", {30'd0, lr0, lr1}, 32'd0);
    chk("mid_rst_sel0", {29'd0, sel0}, 32'd4);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check_idle("mid_after");
    chk("mid_after_lready", {30'd0, lr0, lr1}, 32'd3);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check_idle("mid_after2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
